// File: rtl/cpu_cycle_ctrl.sv
// cpu_cycle_ctrl: instruction-cycle sequencer (fetch/decode/exec/mem/wb) driving datapath strobes and the memory handshake.
// Optional build macro CYCLE_CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter; otherwise retired_cnt is tied to 0.
module cpu_cycle_ctrl #(
    parameter int ICYCLE_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                op_load,
    input  logic                op_store,
    input  logic                op_halt,
    input  logic                op_wb,
    input  logic                stall,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_load,
    output logic                alu_en,
    output logic                reg_we,
    output logic                pc_en,
    output logic                retire,
    output logic                halted,
    output logic                fault,
    output logic [ICYCLE_W-1:0] icycle,
    output logic [31:0]         retired_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam bit              TO_EN   = MEM_TIMEOUT != 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

    state_t          state, state_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic            is_store, mem_phase, timed_out;

    // a simultaneous load+store is a load, so a store needs op_load low
    assign is_store  = op_store & ~op_load;
    assign mem_phase = (state == FETCH) || (state == MEM);
    // this is the last permitted request cycle; an ack in it still wins
    assign timed_out = TO_EN && (to_cnt == TO_LAST) && !mem_ack;

    assign mem_req = mem_phase;
    assign mem_we  = (state == MEM) && is_store;
    assign halted  = state == HALT;
    assign fault   = state == FAULT;
    assign icycle  = ICYCLE_W'(state);

    // state register and request-timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= HALT;
            to_cnt <= '0;
        end else begin
            state  <= state_nx;
            to_cnt <= to_cnt_nx;
        end
    end

    // next state and strobes; stall freezes DECODE/EXEC/WB and kills their strobes
    always_comb begin
        state_nx = state;
        ir_load  = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        pc_en    = 1'b0;
        retire   = 1'b0;
        case (state)
            HALT: state_nx = start ? FETCH : HALT;
            FETCH: begin
                if (mem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = DECODE;
                end else if (timed_out) begin
                    state_nx = FAULT;
                end
            end
            DECODE: begin
                if (!stall) begin
                    retire   = op_halt;
                    state_nx = op_halt ? HALT : EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    alu_en = 1'b1;
                    if (op_load || op_store) begin
                        state_nx = MEM;
                    end else if (op_wb) begin
                        state_nx = WB;
                    end else begin
                        pc_en    = 1'b1;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    pc_en    = is_store;
                    retire   = is_store;
                    state_nx = is_store ? FETCH : WB;
                end else if (timed_out) begin
                    state_nx = FAULT;
                end
            end
            WB: begin
                if (!stall) begin
                    reg_we   = 1'b1;
                    pc_en    = 1'b1;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FAULT;
        endcase
    end

    // counter restarts on any transition and counts unacknowledged request cycles
    always_comb begin
        to_cnt_nx = to_cnt;
        if (state_nx != state) to_cnt_nx = '0;
        else if (mem_phase && !mem_ack) to_cnt_nx = to_cnt + 1'b1;
    end

`ifdef CYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] ret_q;

    // retired-instruction count, wraps naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ret_q <= '0;
        else if (retire) ret_q <= ret_q + 32'd1;
    end

    assign retired_cnt = ret_q;
`else
    assign retired_cnt = 32'd0;
`endif

endmodule
